// File: rtl/never8_pkg.sv
// Shared definitions for the Never8 multi-byte arithmetic sequencer.
package never8_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/eight_bit_adder.sv
// Combinational 8-bit adder with carry-in and carry-out.
module eight_bit_adder
    import never8_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);

    // 9-bit sum keeps the carry out of bit 7.
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial wide adder: feeds eight_bit_adder one byte per clock, LSB
// first, chaining the carry. Optional macro SUBTRACT_EN adds a 'sub' port
// selecting A - B - borrow_in.
//
// state | meaning
// IDLE  | waiting for start; results hold
// RUN   | one operand byte added per clock
// DONE  | single-cycle result-valid (done) state
module multibyte_add_seq
    import never8_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [BYTE_W*NBYTES-1:0] op_a,
    input  logic [BYTE_W*NBYTES-1:0] op_b,
    input  logic                     cin,
`ifdef SUBTRACT_EN
    input  logic                     sub,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout,
    output logic                     zero
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    seq_state_t               state_q, state_d;
    logic [IDX_W-1:0]         idx_q;
    logic                     carry_q;
    logic [BYTE_W*NBYTES-1:0] a_q, b_q, sum_q, sum_next;
    logic                     cout_q, zero_q;
    logic [BYTE_W-1:0]        a_byte, b_byte, s_byte;
    logic                     add_cout, final_cout, carry_init;
`ifdef SUBTRACT_EN
    logic                     sub_q;
`endif

    eight_bit_adder u_adder (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .s    (s_byte),
        .cout (add_cout)
    );

    // Select the current byte pair and build the sum with that byte replaced.
    always_comb begin
        a_byte   = a_q[int'(idx_q)*BYTE_W +: BYTE_W];
        b_byte   = b_q[int'(idx_q)*BYTE_W +: BYTE_W];
`ifdef SUBTRACT_EN
        // Subtraction as A + ~B + ~borrow_in; borrow-out is the inverted carry.
        if (sub_q) begin
            b_byte = ~b_byte;
        end
        final_cout = sub_q ? ~add_cout : add_cout;
        carry_init = sub ? ~cin : cin;
`else
        final_cout = add_cout;
        carry_init = cin;
`endif
        sum_next = sum_q;
        sum_next[int'(idx_q)*BYTE_W +: BYTE_W] = s_byte;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, byte walk and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
`ifdef SUBTRACT_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        carry_q <= carry_init;
                        idx_q   <= '0;
`ifdef SUBTRACT_EN
                        sub_q   <= sub;
`endif
                    end
                end
                RUN: begin
                    sum_q   <= sum_next;
                    carry_q <= add_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q <= final_cout;
                        zero_q <= (sum_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench: a 4-byte and a 1-byte instance checked against
// plain wide-integer arithmetic.
module tb_multibyte_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start4, cin4, sub4;
    logic [31:0] a4, b4, sum4;
    logic        busy4, done4, cout4, zero4;

    logic        start1, cin1, sub1;
    logic [7:0]  a1, b1, sum1;
    logic        busy1, done1, cout1, zero1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multibyte_add_seq #(.NBYTES(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .op_a  (a4),
        .op_b  (b4),
        .cin   (cin4),
`ifdef SUBTRACT_EN
        .sub   (sub4),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4),
        .zero  (zero4)
    );

    multibyte_add_seq #(.NBYTES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .op_a  (a1),
        .op_b  (b1),
        .cin   (cin1),
`ifdef SUBTRACT_EN
        .sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1),
        .zero  (zero1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: (sum, carry/borrow) of a wide add or subtract.
    function automatic logic [32:0] ref4(input logic [31:0] a, input logic [31:0] b,
                                         input logic c, input logic s);
        if (s) return {1'b0, a} - {1'b0, b} - {32'd0, c};
        return {1'b0, a} + {1'b0, b} + {32'd0, c};
    endfunction

    function automatic logic [8:0] ref1(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic s);
        if (s) return {1'b0, a} - {1'b0, b} - {8'd0, c};
        return {1'b0, a} + {1'b0, b} + {8'd0, c};
    endfunction

    // Called at the negedge after the accepting edge; waits for done.
    task automatic wait_done4(input logic [32:0] exp, input string tag);
        int k = 0;
        while (!done4 && k < 40) begin
            @(posedge clk); @(negedge clk); k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'd4);
        chk({tag, "_sum"}, 64'(sum4), 64'(exp[31:0]));
        chk({tag, "_cout"}, 64'(cout4), 64'(exp[32]));
        chk({tag, "_zero"}, 64'(zero4), 64'(exp[31:0] == 32'd0));
        @(posedge clk); @(negedge clk);
        chk({tag, "_done_off"}, 64'({done4, busy4}), 64'd0);
        chk({tag, "_hold"}, 64'(sum4), 64'(exp[31:0]));
    endtask

    task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic s, input string tag);
        logic [32:0] exp = ref4(a, b, c, s);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c; sub4 = s; start4 = 1'b1;
        @(posedge clk); @(negedge clk);
        start4 = 1'b0;
        a4 = $urandom; b4 = $urandom; cin4 = 1'($urandom); sub4 = 1'($urandom);
        chk({tag, "_busy"}, 64'(busy4), 64'd1);
        wait_done4(exp, tag);
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic s, input string tag);
        logic [8:0] exp = ref1(a, b, c, s);
        int k = 0;
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; sub1 = s; start1 = 1'b1;
        @(posedge clk); @(negedge clk);
        start1 = 1'b0;
        a1 = 8'($urandom); b1 = 8'($urandom);
        while (!done1 && k < 20) begin
            @(posedge clk); @(negedge clk); k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'd1);
        chk({tag, "_sum"}, 64'(sum1), 64'(exp[7:0]));
        chk({tag, "_cout"}, 64'(cout1), 64'(exp[8]));
        chk({tag, "_zero"}, 64'(zero1), 64'(exp[7:0] == 8'd0));
        @(posedge clk); @(negedge clk);
        chk({tag, "_done_off"}, 64'(done1), 64'd0);
    endtask

    initial begin
        logic [32:0] e;
        logic        rs;
        int          k;
        int          dcount;

        rst_n = 1'b0;
        start4 = 1'b1; a4 = 32'd5; b4 = 32'd6; cin4 = 1'b0; sub4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", 64'({busy4, done4, sum4, cout4, zero4}), 64'd0);

        // Release with start held: accepted on the very next edge.
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        start4 = 1'b0;
        chk("rel_busy", 64'(busy4), 64'd1);
        wait_done4(ref4(32'd5, 32'd6, 1'b0, 1'b0), "rel");

        run4(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "bytecarry");
        run4(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, "mixed");

        // Busy lockout: held start with changed operands is ignored until IDLE.
        @(negedge clk);
        a4 = 32'd1; b4 = 32'd1; cin4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
        @(posedge clk); @(negedge clk);
        a4 = 32'hAAAA_AAAA;
        k = 0;
        while (!done4 && k < 40) begin
            @(posedge clk); @(negedge clk); k++;
        end
        chk("lock_lat", 64'(k), 64'd4);
        chk("lock_sum", 64'(sum4), 64'd2);
        @(posedge clk); @(negedge clk);
        chk("lock_idle", 64'(busy4), 64'd0);
        @(posedge clk); @(negedge clk);
        start4 = 1'b0;
        chk("lock_reacc", 64'(busy4), 64'd1);
        wait_done4(ref4(32'hAAAA_AAAA, 32'd1, 1'b0, 1'b0), "lock2");

        // Full wrap leaves cout=1/zero=1, then abort a run mid-way.
        run4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "wrap");
        @(negedge clk);
        a4 = 32'h1234_5678; b4 = 32'h0101_0101; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); @(negedge clk);
        start4 = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out", 64'({busy4, done4, sum4, cout4, zero4}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            if (done4 || busy4) dcount++;
        end
        chk("abort_nodone", 64'(dcount), 64'd0);
        run4(32'd3, 32'd4, 1'b0, 1'b0, "post_abort");

        for (int i = 0; i < 20; i++) begin
`ifdef SUBTRACT_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run4($urandom, $urandom, 1'($urandom), rs, $sformatf("rnd%0d", i));
        end

        run1(8'h80, 8'h80, 1'b0, 1'b0, "n1_wrap");
        run1(8'h7F, 8'h00, 1'b1, 1'b0, "n1_carryin");
`ifdef SUBTRACT_EN
        run1(8'h05, 8'h07, 1'b0, 1'b1, "n1_sub");
        run1(8'h07, 8'h05, 1'b1, 1'b1, "n1_sub_bin");
        run4(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, "sub_borrow");
        run4(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, "sub_under");
`endif
        for (int i = 0; i < 6; i++) begin
`ifdef SUBTRACT_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run1(8'($urandom), 8'($urandom), 1'($urandom), rs, $sformatf("n1_rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Sequencer sitting directly upstream of eight_bit_adder. It performs NBYTES-wide additions by feeding the adder one byte per clock, LSB first, and chaining cout back into cin.
- Latches wide operands on a start pulse. Accumulates sum bytes into a result register. Reports completion with a one-cycle done pulse plus final carry and zero flags.
- Used by the Never8 datapath for 16/32-bit arithmetic without widening the ALU.

Parameters:
- NBYTES, 4, number of 8-bit bytes per operand; legal range 1..16.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new addition; sampled only in IDLE
- op_a  input  8*NBYTES  operand A, latched when start is accepted
- op_b  input  8*NBYTES  operand B, latched when start is accepted
- cin  input  1  carry-in for byte 0, latched when start is accepted
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; result valid
- sum  output  8*NBYTES  result register
- cout  output  1  carry out of the most significant byte
- zero  output  1  high when sum == 0

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, zero=0. Internal byte index=0, carry=0.
- States: IDLE, RUN, DONE.
- IDLE: on the edge sampling start=1 (edge E0):
  - latch op_a, op_b, cin;
  - idx=0; state -> RUN.
  - start=0 keeps IDLE.
- RUN: each edge, the adder computes byte idx of A + byte idx of B + carry (combinational instance).
  - Write s into sum byte idx; carry <= cout; idx++.
  - On the edge writing byte NBYTES-1 (edge E0+NBYTES): state -> DONE, done <= 1, cout <= adder cout, zero <= (full new sum == 0).
- DONE: lasts exactly one cycle. Next edge: state -> IDLE, done <= 0.
- Latency: done is high in the cycle between edges E0+NBYTES and E0+NBYTES+1. busy is high from E0 until E0+NBYTES+1.
- Next accept: earliest at edge E0+NBYTES+2, with start held or re-asserted.
- start while RUN or DONE is ignored entirely; latched operands are unchanged.
- sum/cout/zero hold their values after done until the next accepted start.
  - They do not change at accept; bytes are overwritten progressively during RUN.
  - zero updates only in the DONE transition.
- Operand changes on op_a/op_b/cin after acceptance have no effect.
- Arithmetic is unsigned modulo 2^(8*NBYTES); carry is propagated between bytes without loss.
- NBYTES=1: RUN lasts one edge; done high in the cycle after E0+1.
- rst_n low at any time, including mid-RUN: immediate abort, all outputs return to reset values. The first start after release is accepted normally.

Optional Feature:
- Macro SUBTRACT_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands.
  - sub=1 computes A - B - cin, with cin meaning borrow-in: each B byte is inverted before the adder, and initial carry = ~cin.
  - cout reports borrow-out (inverted final carry).
  - sub=0 behaves identically to the base block.
- Undefined: no sub port; addition only.

Decomposition:
- Shared package never8_pkg:
  - BYTE_W=8 constant;
  - seq_state_t enum {IDLE, RUN, DONE}.
- One sub-module, instantiated once: the existing eight_bit_adder (ports a, b, cin, s, cout).
- Index counter width: clog2 of NBYTES, minimum 1 bit.

Test Plan (NBYTES=4 unless noted):
- Reset: hold rst_n=0 with start=1 -> busy=0, done=0, sum=0x00000000, cout=0, zero=0. Release -> start accepted on next edge.
- Byte-boundary carry: a=0x000000FF, b=0x00000001, cin=0 -> done high exactly in the cycle after the 4th post-accept edge; sum=0x00000100, cout=0, zero=0; busy for 5 cycles.
- Full wrap: a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, zero=1. Repeat with a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0.
- Busy lockout:
  - accept a=1, b=1, then during RUN and DONE drive start=1 with a=0xAAAAAAAA -> first result sum=0x00000002;
  - the held start is then accepted at E0+6 and yields 0xAAAAAAAB (b unchanged, =1).
- Reset mid-op: pulse rst_n low two edges after accept -> outputs cleared at once, no done. New start a=3, b=4 -> sum=0x00000007.
- NBYTES=1 instance with SUBTRACT_EN: a=0x05, b=0x07, sub=1, cin=0 -> sum=0xFE, cout(borrow)=1, done one cycle after E0+1. sub=0 with a=0x80, b=0x80 -> sum=0x00, cout=1, zero=1.
